// File: rtl/key_irq_queue_if.sv
// key_irq_queue_if
// Bundles the keyboard-side and CPU-side signals of key_irq_queue.
//   pressed, pressedKey, enable : key event source (level + scan code + gate)
//   ack, clrOvf                 : CPU interrupt acknowledge, overflow clear
//   irq, intData, count,
//   overflow                    : interrupt request, presented key, stored
//                                 entries, sticky lost-event flag
// master = the side driving keys and acknowledges; slave = the queue itself.
interface key_irq_queue_if #(
  parameter int DEPTH = 8,
  parameter int KW    = 9
);
  logic                    pressed;
  logic [KW-1:0]           pressedKey;
  logic                    enable;
  logic                    ack;
  logic                    clrOvf;
  logic                    irq;
  logic [15:0]             intData;
  logic [$clog2(DEPTH):0]  count;
  logic                    overflow;

  modport master (
    output pressed, pressedKey, enable, ack, clrOvf,
    input  irq, intData, count, overflow
  );

  modport slave (
    input  pressed, pressedKey, enable, ack, clrOvf,
    output irq, intData, count, overflow
  );
endinterface

// File: rtl/key_irq_queue.sv
// key_irq_queue
// Queues rising-edge key events and presents them to a CPU one at a time as
// interrupts. A key is popped from the FIFO into intData when the presenter
// is idle; irq stays high until ack, then a one-cycle gap state guarantees
// irq is low for at least two cycles between interrupts.
// Ports:
//   clk  - single clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   bus  - key_irq_queue_if.slave (key inputs, CPU handshake, status)
module key_irq_queue #(
  parameter int DEPTH = 8,
  parameter int KW    = 9
) (
  input  logic            clk,
  input  logic            rst,
  key_irq_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_t;

  state_t          state_r;
  state_t          next_state_s;
  logic [KW-1:0]   mem_r [DEPTH];
  logic [AW-1:0]   wptr_r;
  logic [AW-1:0]   rptr_r;
  logic [CW-1:0]   count_r;
  logic            pressed_prev_r;
  logic            irq_r;
  logic            overflow_r;
  logic [15:0]     int_data_r;

  logic            event_s;
  logic            full_s;
  logic            pop_s;
  logic            push_s;
  logic            ovf_set_s;

  // Event detection and push/pop/overflow decisions for this edge.
  always_comb begin
    event_s   = bus.pressed & ~pressed_prev_r;
    full_s    = (count_r == DEPTH_C);
    pop_s     = (state_r == IDLE) && (count_r != {CW{1'b0}});
    // A full FIFO still takes the key when the head leaves at the same edge.
    push_s    = event_s & bus.enable & (~full_s | pop_s);
    ovf_set_s = event_s & bus.enable & full_s & ~pop_s;
  end

  // Presenter next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (pop_s) begin
          next_state_s = PRESENT;
        end else begin
          next_state_s = IDLE;
        end
      end
      PRESENT: begin
        if (bus.ack) begin
          next_state_s = GAP;
        end else begin
          next_state_s = PRESENT;
        end
      end
      GAP:     next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Presenter state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Key storage, written at the tail on an accepted push.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem_r[wptr_r] <= bus.pressedKey;
    end
  end

  // Pointers, occupancy and edge-detect history.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r         <= {AW{1'b0}};
      rptr_r         <= {AW{1'b0}};
      count_r        <= {CW{1'b0}};
      // Loading the live level means a key held through reset is no event.
      pressed_prev_r <= bus.pressed;
    end else begin
      pressed_prev_r <= bus.pressed;
      if (push_s) begin
        wptr_r <= wptr_r + AW'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered CPU-facing outputs: irq, presented key, sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_r      <= 1'b0;
      int_data_r <= 16'h0000;
      overflow_r <= 1'b0;
    end else begin
      irq_r <= (next_state_s == PRESENT);
      if (pop_s) begin
        int_data_r <= 16'(mem_r[rptr_r]);
      end
      // A lost event at the same edge beats the clear.
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (bus.clrOvf) begin
        overflow_r <= 1'b0;
      end
    end
  end

  assign bus.irq      = irq_r;
  assign bus.intData  = int_data_r;
  assign bus.count    = count_r;
  assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_key_irq_queue.sv
// tb_key_irq_queue
// Self-checking bench for key_irq_queue (DEPTH=8, KW=9): a constant vector
// table, directed multi-cycle sequences and randomized traffic, all compared
// against a queue-based reference model of the key/interrupt behaviour.
module tb_key_irq_queue;
  localparam int DEPTH = 8;
  localparam int KW    = 9;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  key_irq_queue_if #(.DEPTH(DEPTH), .KW(KW)) bus ();

  key_irq_queue #(.DEPTH(DEPTH), .KW(KW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [KW-1:0] mq[$];
  bit            m_irq;
  logic [15:0]   m_data;
  bit            m_ovf;
  bit            m_prev;
  int            m_gap;

  task automatic model_edge();
    bit ev;
    bit can_pop;
    bit ovf_set;
    logic [KW-1:0] k;
    if (rst) begin
      mq.delete();
      m_irq  = 1'b0;
      m_data = 16'h0000;
      m_ovf  = 1'b0;
      m_gap  = 0;
      m_prev = bus.pressed;
      return;
    end
    ev      = bus.pressed && !m_prev;
    m_prev  = bus.pressed;
    ovf_set = 1'b0;
    can_pop = !m_irq && (m_gap == 0) && (mq.size() > 0);
    if (m_irq && bus.ack) begin
      m_irq = 1'b0;
      m_gap = 1;
    end else if (m_gap > 0) begin
      m_gap--;
    end
    if (can_pop) begin
      k      = mq.pop_front();
      m_irq  = 1'b1;
      m_data = 16'(k);
    end
    if (ev && bus.enable) begin
      if (mq.size() < DEPTH) mq.push_back(bus.pressedKey);
      else ovf_set = 1'b1;
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (bus.clrOvf) m_ovf = 1'b0;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic r, input logic p, input logic [KW-1:0] k,
                        input logic e, input logic a, input logic c);
    rst            = r;
    bus.pressed    = p;
    bus.pressedKey = k;
    bus.enable     = e;
    bus.ack        = a;
    bus.clrOvf     = c;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cmpm(input string tag);
    chk({tag, "_irq"},      32'(bus.irq),      32'(m_irq));
    chk({tag, "_intData"},  32'(bus.intData),  32'(m_data));
    chk({tag, "_count"},    32'(bus.count),    32'(mq.size()));
    chk({tag, "_overflow"}, 32'(bus.overflow), 32'(m_ovf));
  endtask

  task automatic tickc(input string tag);
    tick();
    cmpm(tag);
  endtask

  task automatic do_reset();
    set_in(1'b1, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0);
    tickc("reset");
    rst = 1'b0;
  endtask

  // One key event: pressed high for a cycle, then low for a cycle.
  task automatic press(input logic [KW-1:0] k, input string tag);
    bus.pressedKey = k;
    bus.pressed    = 1'b1;
    tickc(tag);
    bus.pressed    = 1'b0;
    tickc(tag);
  endtask

  // Wait (bounded) for irq, check the key, ack for one cycle, then report
  // how many sampled cycles irq stayed low afterwards (bounded to 10).
  task automatic deliver(input logic [15:0] exp, input string tag, output int low);
    for (int i = 0; i < 20 && !bus.irq; i++) tickc(tag);
    chk({tag, "_irq_wait"}, 32'(bus.irq), 32'd1);
    chk({tag, "_key"}, 32'(bus.intData), 32'(exp));
    bus.ack = 1'b1;
    tickc(tag);
    bus.ack = 1'b0;
    low = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.irq) break;
      low++;
      tickc(tag);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          r, p;
    logic [KW-1:0] k;
    logic          e, a, c;
    logic          x_irq;
    logic [15:0]   x_data;
    logic [3:0]    x_cnt;
    logic          x_ovf;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mkv(input logic r, input logic p, input logic [KW-1:0] k,
                               input logic e, input logic a, input logic c,
                               input logic xi, input logic [15:0] xd,
                               input logic [3:0] xc, input logic xo);
    vec_t v;
    v.r = r; v.p = p; v.k = k; v.e = e; v.a = a; v.c = c;
    v.x_irq = xi; v.x_data = xd; v.x_cnt = xc; v.x_ovf = xo;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int low;
    logic [15:0] exp_keys [3];

    // reset, then key 01C held three cycles: push, pop, irq
    vq.push_back(mkv(1'b1, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0));
    vq.push_back(mkv(1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0));
    vq.push_back(mkv(1'b0, 1'b1, 9'h01C, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd1, 1'b0));
    vq.push_back(mkv(1'b0, 1'b1, 9'h01C, 1'b1, 1'b0, 1'b0, 1'b1, 16'h001C, 4'd0, 1'b0));
    vq.push_back(mkv(1'b0, 1'b1, 9'h01C, 1'b1, 1'b0, 1'b0, 1'b1, 16'h001C, 4'd0, 1'b0));
    vq.push_back(mkv(1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h001C, 4'd0, 1'b0));
    // ack clears irq, data held; ack in the idle phase is ignored
    vq.push_back(mkv(1'b0, 1'b0, 9'h000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h001C, 4'd0, 1'b0));
    vq.push_back(mkv(1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h001C, 4'd0, 1'b0));
    vq.push_back(mkv(1'b0, 1'b0, 9'h000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h001C, 4'd0, 1'b0));
    // enable=0: four events discarded silently
    for (int i = 0; i < 4; i++) begin
      vq.push_back(mkv(1'b0, 1'b1, 9'h055, 1'b0, 1'b0, 1'b0, 1'b0, 16'h001C, 4'd0, 1'b0));
      vq.push_back(mkv(1'b0, 1'b0, 9'h055, 1'b0, 1'b0, 1'b0, 1'b0, 16'h001C, 4'd0, 1'b0));
    end
    vq.push_back(mkv(1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h001C, 4'd0, 1'b0));
    // reset with pressed held high: no event after release of reset
    vq.push_back(mkv(1'b1, 1'b1, 9'h0AB, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0));
    vq.push_back(mkv(1'b0, 1'b1, 9'h0AB, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0));
    vq.push_back(mkv(1'b0, 1'b1, 9'h0AB, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0));
    vq.push_back(mkv(1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0));

    foreach (vq[i]) begin
      set_in(vq[i].r, vq[i].p, vq[i].k, vq[i].e, vq[i].a, vq[i].c);
      tick();
      chk($sformatf("vec%0d_irq", i),      32'(bus.irq),      32'(vq[i].x_irq));
      chk($sformatf("vec%0d_intData", i),  32'(bus.intData),  32'(vq[i].x_data));
      chk($sformatf("vec%0d_count", i),    32'(bus.count),    32'(vq[i].x_cnt));
      chk($sformatf("vec%0d_overflow", i), 32'(bus.overflow), 32'(vq[i].x_ovf));
    end

    // three keys queued, delivered in order with a two-cycle irq gap
    do_reset();
    press(9'h04D, "q3");
    press(9'h032, "q3");
    press(9'h021, "q3");
    exp_keys[0] = 16'h004D;
    exp_keys[1] = 16'h0032;
    exp_keys[2] = 16'h0021;
    for (int i = 0; i < 3; i++) begin
      deliver(exp_keys[i], $sformatf("q3_k%0d", i), low);
      if (i < 2) chk($sformatf("q3_gap%0d", i), 32'(low), 32'd2);
    end
    chk("q3_final_count", 32'(bus.count), 32'd0);

    // overflow: irq never acked, 10 events
    do_reset();
    for (int i = 0; i < 10; i++) press(9'(9'h100 + i), "ovf");
    chk("ovf_count", 32'(bus.count), 32'd8);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < 9; i++) deliver(16'(16'h0100 + i), $sformatf("ovf_k%0d", i), low);
    chk("ovf_flag_kept", 32'(bus.overflow), 32'd1);
    bus.clrOvf = 1'b1;
    tickc("ovf_clr");
    bus.clrOvf = 1'b0;
    chk("ovf_cleared", 32'(bus.overflow), 32'd0);

    // full FIFO: push and ack-driven pop at the same edge
    do_reset();
    for (int i = 0; i < 9; i++) press(9'(9'h040 + i), "full");
    chk("full_count", 32'(bus.count), 32'd8);
    bus.ack = 1'b1;
    tickc("full_ack");
    bus.ack = 1'b0;
    tickc("full_gap");
    bus.pressedKey = 9'h0AA;
    bus.pressed    = 1'b1;
    tickc("full_both");
    chk("full_both_count", 32'(bus.count), 32'd8);
    chk("full_both_ovf", 32'(bus.overflow), 32'd0);
    chk("full_both_key", 32'(bus.intData), 32'h0041);
    bus.pressed = 1'b0;
    for (int i = 0; i < 8; i++) deliver(16'(16'h0041 + i), $sformatf("full_k%0d", i), low);
    deliver(16'h00AA, "full_last", low);

    // reset mid-operation with pressed held high
    do_reset();
    for (int i = 0; i < 6; i++) press(9'(9'h060 + i), "mid");
    chk("mid_irq", 32'(bus.irq), 32'd1);
    chk("mid_count", 32'(bus.count), 32'd5);
    rst = 1'b1;
    bus.pressed = 1'b1;
    tickc("mid_rst");
    chk("mid_rst_irq", 32'(bus.irq), 32'd0);
    chk("mid_rst_data", 32'(bus.intData), 32'd0);
    chk("mid_rst_count", 32'(bus.count), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tickc("mid_after");
    chk("mid_after_count", 32'(bus.count), 32'd0);
    chk("mid_after_irq", 32'(bus.irq), 32'd0);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      rst            = ($urandom_range(0, 199) == 0);
      bus.pressed    = ($urandom_range(0, 1) == 1);
      bus.pressedKey = KW'($urandom());
      bus.enable     = ($urandom_range(0, 7) != 0);
      bus.ack        = (i < 400) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
      bus.clrOvf     = ($urandom_range(0, 15) == 0);
      tickc("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/key_irq_queue.md
KEY_IRQ_QUEUE -- requirements
Module: key_irq_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter KW, default 9, key code width.
REQ-003 SHALL have port clk input 1: single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst input 1: reset, synchronous, active-high.
REQ-005 SHALL have port pressed input 1: key-valid level from keyboard reader.
REQ-006 SHALL have port pressedKey input KW: scan code, valid while pressed=1.
REQ-007 SHALL have port enable input 1: 1 = queue key events, 0 = discard them.
REQ-008 SHALL have port ack input 1: CPU interrupt acknowledge (turnOffIRQ).
REQ-009 SHALL have port clrOvf input 1: clears overflow flag.
REQ-010 SHALL have port irq output 1: interrupt request to CPU.
REQ-011 SHALL have port intData output 16: current key, {zeros, key}.
REQ-012 SHALL have port count output $clog2(DEPTH)+1: entries stored, excluding the one presented.
REQ-013 SHALL have port overflow output 1: sticky lost-event flag.

Function
REQ-014 SHALL register pressed into pressedPrev each cycle; event = pressed & !pressedPrev.
REQ-015 On an event with enable=1 and count<DEPTH, SHALL write pressedKey at the tail at that edge, wptr+1 mod DEPTH.
REQ-016 On an event with enable=1 and count==DEPTH, SHALL drop the key, set overflow=1, leave FIFO unchanged.
REQ-017 On an event with enable=0, SHALL drop the key silently; overflow is unchanged.
REQ-018 SHALL implement FSM states IDLE, PRESENT, GAP.
REQ-019 IDLE with count>0: SHALL pop head into intData, set irq=1, rptr+1 mod DEPTH, go to PRESENT (same edge).
REQ-020 IDLE with count==0: SHALL stay in IDLE with irq=0.
REQ-021 PRESENT: SHALL hold irq=1 and intData stable until ack=1 is sampled.
REQ-022 PRESENT with ack=1: SHALL clear irq and go to GAP; intData is held.
REQ-023 GAP: SHALL go to IDLE unconditionally, so irq stays low >=2 cycles between interrupts.
REQ-024 SHALL ignore ack in IDLE and GAP.
REQ-025 On push and pop at the same edge, SHALL perform both; count is unchanged, and a full FIFO accepts the push.
REQ-026 An event on an empty FIFO in IDLE SHALL give irq=1 two edges after pressed is first sampled high (write edge k, pop edge k+1).
REQ-027 count SHALL equal pushes minus pops, with pointer wrap modulo DEPTH.
REQ-028 clrOvf=1 SHALL clear overflow; an overflow event at the same edge SHALL win (overflow=1).
REQ-029 intData[15:KW] SHALL be zero.

Reset
REQ-030 rst=1 SHALL set state=IDLE, irq=0, intData=0, count=0, rptr=wptr=0, overflow=0.
REQ-031 rst=1 SHALL load pressedPrev with pressed, so a key held through reset gives no event.
REQ-032 Reset mid-operation SHALL discard all queued keys and any pending interrupt in one cycle.
REQ-033 Reset SHALL take priority over every other input at the same edge.

Verification
REQ-034 Reset, enable=1, pressed 0->1 with key 9'h01C held 3 cycles -> one push; irq=1 two edges later; intData=16'h001C; count=0.
REQ-035 Three keys 9'h04D, 9'h032, 9'h021 queued, ack pulsed 1 cycle after each irq -> intData sequence 004D, 0032, 0021; irq low exactly 2 cycles between them; final count=0.
REQ-036 DEPTH=8, irq pending and never acked, 10 events -> count=8, overflow=1; after acks, 9 keys are delivered in order; clrOvf -> overflow=0.
REQ-037 FIFO full and ack-driven pop at the same edge as a new event -> new key accepted, count stays 8, overflow stays 0.
REQ-038 enable=0, 4 events -> count=0, irq=0, overflow=0.
REQ-039 rst asserted with irq=1, count=5, pressed held high -> next cycle all outputs zero; no event after rst drops while pressed stays high.
